// File: rtl/wash_cycle_controller.sv
// Wash program sequencer: FILL -> WASH -> DRAIN -> SPIN per pass, then DONE.
// Moore outputs change on the edge entering a state. FAULT holds until Reset.
module wash_cycle_controller #(
  parameter int CNT_W      = 10,
  parameter int FILL_MAX   = 1000,
  parameter int WASH_MAX   = 1000,
  parameter int DRAIN_MAX  = 1000,
  parameter int SPIN_TICKS = 500,
  parameter int RINSES     = 1
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       StartBtn,
  input  logic       DoorClosed,
  input  logic       WaterFull,
  input  logic       WaterEmpty,
  input  logic       WashDone,
  output logic       WashStart,
  output logic       FillValve,
  output logic       DrainPump,
  output logic       SpinMotor,
  output logic       DoorLock,
  output logic       Done,
  output logic       Fault,
  output logic [2:0] State
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_SPIN  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  localparam logic [CNT_W-1:0] FILL_LIM  = CNT_W'(FILL_MAX - 1);
  localparam logic [CNT_W-1:0] WASH_LIM  = CNT_W'(WASH_MAX - 1);
  localparam logic [CNT_W-1:0] DRAIN_LIM = CNT_W'(DRAIN_MAX - 1);
  localparam logic [CNT_W-1:0] SPIN_LIM  = CNT_W'(SPIN_TICKS - 1);
  localparam logic [3:0]       RINSES_V  = 4'(RINSES);

  logic [2:0]       state, next_state;
  logic [CNT_W-1:0] timer;
  logic [3:0]       pass;

  // State register, phase timer and pass counter
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IDLE;
      timer <= '0;
      pass  <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;
      if (state == S_IDLE && next_state == S_FILL)
        pass <= '0;
      else if (state == S_SPIN && next_state == S_FILL)
        pass <= pass + 4'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (StartBtn && DoorClosed) next_state = S_FILL;
      end
      S_FILL: begin
        if (!DoorClosed)            next_state = S_FAULT;
        else if (WaterFull)         next_state = S_WASH;
        else if (timer == FILL_LIM) next_state = S_FAULT;
      end
      S_WASH: begin
        if (!DoorClosed)            next_state = S_FAULT;
        else if (WashDone)          next_state = S_DRAIN;
        else if (timer == WASH_LIM) next_state = S_FAULT;
      end
      S_DRAIN: begin
        if (!DoorClosed)             next_state = S_FAULT;
        else if (WaterEmpty)         next_state = S_SPIN;
        else if (timer == DRAIN_LIM) next_state = S_FAULT;
      end
      S_SPIN: begin
        if (!DoorClosed)
          next_state = S_FAULT;
        else if (timer == SPIN_LIM)
          next_state = (pass < RINSES_V) ? S_FILL : S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    WashStart = 1'b0;
    FillValve = 1'b0;
    DrainPump = 1'b0;
    SpinMotor = 1'b0;
    DoorLock  = 1'b0;
    Done      = 1'b0;
    Fault     = 1'b0;
    case (state)
      S_FILL: begin
        FillValve = 1'b1;
        DoorLock  = 1'b1;
      end
      S_WASH: begin
        WashStart = 1'b1;
        DoorLock  = 1'b1;
      end
      S_DRAIN: begin
        DrainPump = 1'b1;
        DoorLock  = 1'b1;
      end
      S_SPIN: begin
        SpinMotor = 1'b1;
        DrainPump = 1'b1;
        DoorLock  = 1'b1;
      end
      S_DONE: Done = 1'b1;
      S_FAULT: begin
        // Keep pumping and locked until the drum is confirmed empty
        Fault     = 1'b1;
        DrainPump = ~WaterEmpty;
        DoorLock  = ~WaterEmpty;
      end
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed bench for wash_cycle_controller with short phase limits.
module tb_wash_cycle_controller;

  logic       CLK = 1'b0;
  logic       Reset, StartBtn, DoorClosed, WaterFull, WaterEmpty, WashDone;
  logic       WashStart, FillValve, DrainPump, SpinMotor, DoorLock, Done, Fault;
  logic [2:0] State;

  int checks = 0;
  int errors = 0;

  wash_cycle_controller #(
    .CNT_W(10), .FILL_MAX(8), .WASH_MAX(16), .DRAIN_MAX(8),
    .SPIN_TICKS(4), .RINSES(1)
  ) dut (
    .CLK(CLK), .Reset(Reset), .StartBtn(StartBtn), .DoorClosed(DoorClosed),
    .WaterFull(WaterFull), .WaterEmpty(WaterEmpty), .WashDone(WashDone),
    .WashStart(WashStart), .FillValve(FillValve), .DrainPump(DrainPump),
    .SpinMotor(SpinMotor), .DoorLock(DoorLock), .Done(Done), .Fault(Fault),
    .State(State)
  );

  always #5 CLK = ~CLK;

  // {WashStart, FillValve, DrainPump, SpinMotor, DoorLock, Done, Fault}
  logic [6:0] outs;
  assign outs = {WashStart, FillValve, DrainPump, SpinMotor, DoorLock, Done, Fault};

  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_FILL   = 7'b0100100;
  localparam logic [6:0] O_WASH   = 7'b1000100;
  localparam logic [6:0] O_DRAIN  = 7'b0010100;
  localparam logic [6:0] O_SPIN   = 7'b0011100;
  localparam logic [6:0] O_DONE   = 7'b0000010;
  localparam logic [6:0] O_FLT_W  = 7'b0010101;
  localparam logic [6:0] O_FLT_E  = 7'b0000001;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; StartBtn = 1'b0; DoorClosed = 1'b1;
    WaterFull = 1'b0; WaterEmpty = 1'b0; WashDone = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic start_run();
    StartBtn = 1'b1;
    tick();
    StartBtn = 1'b0;
    chk("start_fill_state", State, 1);
    chk("start_fill_outs", outs, O_FILL);
  endtask

  // One normal pass from FILL timer 0; exp_after is the state after SPIN
  task automatic do_pass(input int exp_after);
    repeat (3) tick();
    chk("fill_wait_state", State, 1);
    WaterFull = 1'b1;
    tick();
    WaterFull = 1'b0;
    chk("wash_state", State, 2);
    chk("wash_outs", outs, O_WASH);
    repeat (5) tick();
    chk("wash_wait_state", State, 2);
    WashDone = 1'b1;
    tick();
    WashDone = 1'b0;
    chk("drain_state", State, 3);
    chk("drain_outs", outs, O_DRAIN);
    repeat (2) tick();
    WaterEmpty = 1'b1;
    tick();
    WaterEmpty = 1'b0;
    chk("spin_state", State, 4);
    chk("spin_outs", outs, O_SPIN);
    repeat (3) tick();
    chk("spin_last_state", State, 4);
    tick();
    chk("after_spin_state", State, exp_after);
  endtask

  initial begin
    // 1: normal two-pass program
    do_reset();
    chk("reset_state", State, 0);
    chk("reset_outs", outs, O_IDLE);
    start_run();
    do_pass(1);
    chk("pass2_fill_outs", outs, O_FILL);
    do_pass(5);
    chk("done_outs", outs, O_DONE);
    tick();
    chk("idle_after_done", State, 0);
    chk("idle_after_done_outs", outs, O_IDLE);
    tick();
    chk("idle_stays", State, 0);

    // 2: fill timeout
    do_reset();
    start_run();
    repeat (7) tick();
    chk("fill_t7_state", State, 1);
    tick();
    chk("fill_timeout_state", State, 6);
    chk("fault_wet_outs", outs, O_FLT_W);
    WaterEmpty = 1'b1;
    #1;
    chk("fault_empty_outs", outs, O_FLT_E);
    StartBtn = 1'b1;
    WashDone = 1'b1;
    repeat (3) tick();
    chk("fault_absorbing", State, 6);
    StartBtn = 1'b0;
    WashDone = 1'b0;

    // 3: door opened mid-WASH
    do_reset();
    start_run();
    WaterFull = 1'b1;
    tick();
    WaterFull = 1'b0;
    chk("door_wash_state", State, 2);
    repeat (3) tick();
    DoorClosed = 1'b0;
    tick();
    chk("door_fault_state", State, 6);
    chk("door_fault_washstart", WashStart, 0);
    chk("door_fault_flag", Fault, 1);

    // 4: start with door open
    do_reset();
    DoorClosed = 1'b0;
    StartBtn = 1'b1;
    repeat (2) tick();
    chk("door_open_idle", State, 0);
    chk("door_open_outs", outs, O_IDLE);
    StartBtn = 1'b0;

    // 5: reset during SPIN of second pass, then a full run
    do_reset();
    start_run();
    do_pass(1);
    repeat (4) tick();
    WaterFull = 1'b1; tick(); WaterFull = 1'b0;
    WashDone = 1'b1; tick(); WashDone = 1'b0;
    WaterEmpty = 1'b1; tick(); WaterEmpty = 1'b0;
    chk("p2_spin_state", State, 4);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("spin_reset_state", State, 0);
    chk("spin_reset_outs", outs, O_IDLE);
    start_run();
    do_pass(1);
    do_pass(5);

    // 6: sensor wins the timeout tie in FILL and DRAIN
    do_reset();
    start_run();
    repeat (7) tick();
    WaterFull = 1'b1;
    tick();
    WaterFull = 1'b0;
    chk("fill_tie_state", State, 2);
    WashDone = 1'b1;
    tick();
    WashDone = 1'b0;
    chk("tie_drain_state", State, 3);
    repeat (7) tick();
    chk("drain_t7_state", State, 3);
    WaterEmpty = 1'b1;
    tick();
    WaterEmpty = 1'b0;
    chk("drain_tie_state", State, 4);
    chk("tie_no_fault", Fault, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
